// File: rtl/sc_rowscan_controller.sv
// Row-scan controller for a 12-line decoder.
// The controller steps the row-select code through rows 1..NUM_ROWS. Each row
// stays selected for a programmable dwell time. An optional all-off blank gap
// can be inserted between rows. A one-cycle frame-done pulse marks the end of
// each full pass.
module sc_rowscan_controller #(
    parameter int DATAWIDTH_DECODER_SELECTION = 4,
    parameter int NUM_ROWS                    = 12,
    parameter int DATAWIDTH_DWELL             = 16
) (
    input  logic                                   SC_ROWSCAN_CLOCK_50,
    input  logic                                   SC_ROWSCAN_RESET_InLow,
    input  logic                                   SC_ROWSCAN_enable_In,
    input  logic                                   SC_ROWSCAN_hold_In,
    input  logic [DATAWIDTH_DWELL-1:0]             SC_ROWSCAN_dwell_InBUS,
    input  logic [3:0]                             SC_ROWSCAN_blank_InBUS,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0] SC_ROWSCAN_selection_OutBUS,
    output logic                                   SC_ROWSCAN_blank_Out,
    output logic                                   SC_ROWSCAN_busy_Out,
    output logic                                   SC_ROWSCAN_frameDone_Out
);

    localparam int SW = DATAWIDTH_DECODER_SELECTION;
    // The counter is shared by dwell and blank timing, so it must fit both.
    localparam int CW = (DATAWIDTH_DWELL > 4) ? DATAWIDTH_DWELL : 4;

    localparam logic [SW-1:0] ROW_FIRST = SW'(1);
    localparam logic [SW-1:0] ROW_LAST  = SW'(NUM_ROWS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t        state;
    logic [SW-1:0] row;
    logic [CW-1:0] cnt;
    logic [3:0]    blank_lat;

    logic [CW-1:0] dwell_load;
    logic [SW-1:0] next_row;

    // Remaining-cycle preload for a new row (dwell of 0 behaves as 1) and the wrapped successor row
    always_comb begin
        dwell_load = '0;
        if (SC_ROWSCAN_dwell_InBUS != '0) begin
            dwell_load = CW'(SC_ROWSCAN_dwell_InBUS) - CW'(1);
        end
        next_row = (row >= ROW_LAST) ? ROW_FIRST : row + SW'(1);
    end

    // Scan FSM with registered outputs; enable-low wins over hold, hold freezes everything
    always_ff @(posedge SC_ROWSCAN_CLOCK_50 or negedge SC_ROWSCAN_RESET_InLow) begin
        if (!SC_ROWSCAN_RESET_InLow) begin
            state                       <= IDLE;
            row                         <= ROW_FIRST;
            cnt                         <= '0;
            blank_lat                   <= '0;
            SC_ROWSCAN_selection_OutBUS <= '0;
            SC_ROWSCAN_blank_Out        <= 1'b1;
            SC_ROWSCAN_busy_Out         <= 1'b0;
            SC_ROWSCAN_frameDone_Out    <= 1'b0;
        end else if (!SC_ROWSCAN_enable_In) begin
            state                       <= IDLE;
            row                         <= ROW_FIRST;
            cnt                         <= '0;
            SC_ROWSCAN_selection_OutBUS <= '0;
            SC_ROWSCAN_blank_Out        <= 1'b1;
            SC_ROWSCAN_busy_Out         <= 1'b0;
            SC_ROWSCAN_frameDone_Out    <= 1'b0;
        end else if (SC_ROWSCAN_hold_In) begin
            SC_ROWSCAN_frameDone_Out <= 1'b0;
        end else begin
            SC_ROWSCAN_frameDone_Out <= 1'b0;
            case (state)
                IDLE: begin
                    state                       <= DWELL;
                    row                         <= ROW_FIRST;
                    cnt                         <= dwell_load;
                    blank_lat                   <= SC_ROWSCAN_blank_InBUS;
                    SC_ROWSCAN_selection_OutBUS <= ROW_FIRST;
                    SC_ROWSCAN_blank_Out        <= 1'b0;
                    SC_ROWSCAN_busy_Out         <= 1'b1;
                end
                DWELL: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        SC_ROWSCAN_frameDone_Out <= (row == ROW_LAST);
                        if (blank_lat != '0) begin
                            // The blank length latched at row entry governs this gap.
                            state                       <= BLANK;
                            cnt                         <= CW'(blank_lat) - CW'(1);
                            SC_ROWSCAN_selection_OutBUS <= '0;
                            SC_ROWSCAN_blank_Out        <= 1'b1;
                        end else begin
                            row                         <= next_row;
                            cnt                         <= dwell_load;
                            blank_lat                   <= SC_ROWSCAN_blank_InBUS;
                            SC_ROWSCAN_selection_OutBUS <= next_row;
                            SC_ROWSCAN_blank_Out        <= 1'b0;
                        end
                    end
                end
                BLANK: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state                       <= DWELL;
                        row                         <= next_row;
                        cnt                         <= dwell_load;
                        blank_lat                   <= SC_ROWSCAN_blank_InBUS;
                        SC_ROWSCAN_selection_OutBUS <= next_row;
                        SC_ROWSCAN_blank_Out        <= 1'b0;
                    end
                end
                default: begin
                    state                       <= IDLE;
                    row                         <= ROW_FIRST;
                    cnt                         <= '0;
                    SC_ROWSCAN_selection_OutBUS <= '0;
                    SC_ROWSCAN_blank_Out        <= 1'b1;
                    SC_ROWSCAN_busy_Out         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sc_rowscan_controller.md
SC_ROWSCAN_CONTROLLER -- requirements
Module: SC_ROWSCAN_CONTROLLER

Interface
REQ-001 Parameter DATAWIDTH_DECODER_SELECTION, default 4, sets the width of the row-select code driven to the 12-line decoder.
REQ-002 Parameter NUM_ROWS, default 12, sets the highest row code; legal codes are 1..NUM_ROWS and 0 means all lines off.
REQ-003 Parameter DATAWIDTH_DWELL, default 16, sets the width of the dwell count.
REQ-004 SC_ROWSCAN_CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-005 SC_ROWSCAN_RESET_InLow  in  1  reset, asynchronous assert, active-low.
REQ-006 SC_ROWSCAN_enable_In  in  1  1 = run the scan, 0 = stop and blank.
REQ-007 SC_ROWSCAN_hold_In  in  1  1 = freeze state, counters and outputs.
REQ-008 SC_ROWSCAN_dwell_InBUS  in  DATAWIDTH_DWELL  cycles each row stays selected; 0 is treated as 1.
REQ-009 SC_ROWSCAN_blank_InBUS  in  4  all-off cycles inserted between rows; 0 = none.
REQ-010 SC_ROWSCAN_selection_OutBUS  out  DATAWIDTH_DECODER_SELECTION  row code to the decoder select input; registered.
REQ-011 SC_ROWSCAN_blank_Out  out  1  1 while the select code is 0; registered.
REQ-012 SC_ROWSCAN_busy_Out  out  1  1 in any state other than IDLE; registered.
REQ-013 SC_ROWSCAN_frameDone_Out  out  1  one-cycle pulse at the end of each full 1..NUM_ROWS pass; registered.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, DWELL and BLANK.
REQ-015 In IDLE: select=0, blank=1, busy=0; enable=1 sampled at an edge SHALL enter DWELL on that edge, with row=1, select=1 and the dwell counter loaded.
REQ-016 Dwell and blank values SHALL be latched on the edge that enters a row (DWELL) and on the edge that enters BLANK; input changes mid-row or mid-blank SHALL have no effect until the next latch.
REQ-017 In DWELL: select=row, blank=0, and the row stays selected for exactly max(D,1) clock cycles.
REQ-018 At the end of DWELL with latched B>0, the FSM SHALL enter BLANK with select=0 for exactly B cycles, then enter DWELL with the next row.
REQ-019 At the end of DWELL with B=0, the FSM SHALL enter DWELL with the next row directly; no zero cycle is inserted.
REQ-020 Next row SHALL be row+1, except row NUM_ROWS, which SHALL wrap to 1; codes above NUM_ROWS SHALL never be driven.
REQ-021 frameDone SHALL be 1 for exactly the first cycle after row NUM_ROWS ends: the first BLANK cycle, or the first row-1 cycle when B=0.
REQ-022 enable=0 sampled in any state SHALL force IDLE on that edge, with select=0 and row reset to 1; the current row is not completed.
REQ-023 hold=1 SHALL freeze state, row, counters and all outputs (frameDone forced 0 while held); counting resumes from the frozen value when hold returns to 0.
REQ-024 If enable=0 and hold=1 occur together, enable SHALL take priority.
REQ-025 Frame period in steady state SHALL be NUM_ROWS*(max(D,1)+B) cycles.

Reset
REQ-026 When RESET_InLow=0, asynchronously and independent of the clock: state=IDLE, row=1, counters=0, select=0, blank=1, busy=0, frameDone=0.
REQ-027 After reset is released, the block SHALL remain in IDLE until enable=1 is sampled; reset asserted mid-scan SHALL abort immediately with no frameDone pulse.

Verification
REQ-028 Reset released, enable=1, D=3, B=0 -> select sequence 1,1,1,2,2,2,...,12,12,12,1; frameDone high on the first cycle of the second row-1 visit; period 36 cycles.
REQ-029 D=2, B=1 -> select sequence 1,1,0,2,2,0,...; blank_Out=1 on the zero cycles; frameDone coincides with the zero cycle after row 12.
REQ-030 D=0, B=0 -> each row is held 1 cycle; select steps 1..12 then wraps to 1; period 12 cycles.
REQ-031 D=5, hold=1 for 4 cycles during cycle 2 of row 3 -> select stays 3 for 9 cycles in total; frameDone delayed by 4 cycles.
REQ-032 enable dropped during row 7 -> next edge select=0, busy=0; re-enable restarts at row 1; a D change during row 4 applies from row 5 onward.
REQ-033 RESET_InLow pulsed low mid-cycle during row 9 -> outputs reach reset values before the next clock edge; no frameDone pulse is produced.
